// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the time-multiplexed neural-network layers.
//   - default layer geometry (inputs per neuron, neurons, operand widths)
//   - layer_state_t : sequencing FSM state encoding
//   - relu()        : width-generic rectifier
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int N_NEUR_DEF = 8;
    localparam int X_W_DEF    = 4;
    localparam int W_W_DEF    = 4;

    // Widest value relu() can handle; callers right-align narrower values.
    localparam int RELU_MAX_W = 64;
    localparam int RELU_IDX_W = $clog2(RELU_MAX_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } layer_state_t;

    // The value occupies bits [w-1:0] of v as a two's-complement number;
    // bit w-1 is its sign. Negative values clamp to zero, others pass.
    function automatic logic [RELU_MAX_W-1:0] relu(
        input logic [RELU_MAX_W-1:0] v,
        input int unsigned           w
    );
        logic [RELU_IDX_W-1:0] sign_idx;
        logic [RELU_MAX_W-1:0] r;
        sign_idx = RELU_IDX_W'(w - 1);
        r        = v;
        if (v[sign_idx]) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// ---------------------------------------------------------------------------
// weight_bank
// Flop-based weight store, DEPTH entries of W_W bits.
//   clk_i    in   clock
//   rst_i    in   synchronous active-high clear of every entry
//   we_i     in   write strobe (already gated by the caller's FSM)
//   waddr_i  in   write address; addresses >= DEPTH are ignored
//   wdata_i  in   write data
//   raddr_i  in   asynchronous read address
//   rdata_o  out  entry at raddr_i (0 for out-of-range addresses)
// ---------------------------------------------------------------------------
module weight_bank #(
    parameter int DEPTH = 32,
    parameter int W_W   = 4,
    parameter int A_W   = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           we_i,
    input  logic [A_W-1:0] waddr_i,
    input  logic [W_W-1:0] wdata_i,
    input  logic [A_W-1:0] raddr_i,
    output logic [W_W-1:0] rdata_o
);

    logic [W_W-1:0] mem_q [DEPTH];
    logic           wr_ok;

    assign wr_ok = we_i && (int'(waddr_i) < DEPTH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/hidden_layer_seq.sv
// ---------------------------------------------------------------------------
// hidden_layer_seq
// Fully-connected hidden layer built around one shared multiply-accumulate
// unit. Each accepted input vector is walked neuron by neuron, one product
// per enabled cycle; every finished neuron sum goes through ReLU into its
// result slot. Weights live in a writable bank loaded while the layer idles.
//
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset, overrides en_i
//   en_i       in   global advance enable; 0 freezes all state
//   w_we_i     in   weight write strobe (honoured only in IDLE with en_i)
//   w_addr_i   in   weight index n*N_IN+k
//   w_data_i   in   weight value, two's-complement
//   x_valid_i  in   input vector valid
//   x_ready_o  out  layer can accept an input vector
//   x_i        in   input vector, input k at [k*X_W +: X_W], unsigned
//   y_valid_o  out  result vector valid
//   y_ready_i  in   downstream accepts the result
//   y_o        out  ReLU outputs, neuron n at [n*ACC_W +: ACC_W]
//   busy_o     out  high while multiply-accumulating
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for an input vector; weight writes accepted here only
// MAC   | one product per enabled cycle, result slot written per neuron
// OUT   | result vector presented until the downstream takes it
// ---------------------------------------------------------------------------
module hidden_layer_seq
    import nn_pkg::*;
#(
    parameter  int N_IN   = N_IN_DEF,
    parameter  int N_NEUR = N_NEUR_DEF,
    parameter  int X_W    = X_W_DEF,
    parameter  int W_W    = W_W_DEF,
    localparam int ACC_W  = X_W + W_W + 1 + $clog2(N_IN),
    localparam int N_W    = N_IN * N_NEUR,
    localparam int WA_W   = (N_W > 1) ? $clog2(N_W) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     w_we_i,
    input  logic [WA_W-1:0]          w_addr_i,
    input  logic [W_W-1:0]           w_data_i,
    input  logic                     x_valid_i,
    output logic                     x_ready_o,
    input  logic [N_IN*X_W-1:0]      x_i,
    output logic                     y_valid_o,
    input  logic                     y_ready_i,
    output logic [N_NEUR*ACC_W-1:0]  y_o,
    output logic                     busy_o
);

    localparam int K_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NN_W = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
    localparam int P_W  = X_W + W_W + 1;

    layer_state_t                state_q, state_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [NN_W-1:0]             n_q, n_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [N_IN*X_W-1:0]         x_q, x_d;
    logic [N_NEUR*ACC_W-1:0]     y_q, y_d;

    logic                        w_we_gated;
    logic [WA_W-1:0]             w_raddr;
    logic [W_W-1:0]              w_rdata;
    logic [X_W-1:0]              x_k;
    logic signed [P_W-1:0]       x_ext;
    logic signed [P_W-1:0]       w_ext;
    logic signed [P_W-1:0]       prod;
    logic signed [ACC_W-1:0]     acc_sum;

    // Writes are ignored while a vector is in flight so its weights stay
    // consistent for the whole pass.
    assign w_we_gated = w_we_i && en_i && (state_q == IDLE);

    weight_bank #(
        .DEPTH (N_W),
        .W_W   (W_W),
        .A_W   (WA_W)
    ) u_weight_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we_gated),
        .waddr_i (w_addr_i),
        .wdata_i (w_data_i),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata)
    );

    // Shared MAC datapath. The input is unsigned, so it gets a zero sign bit
    // before the signed multiply.
    always_comb begin
        w_raddr = WA_W'(int'(n_q) * N_IN + int'(k_q));
        x_k     = x_q[int'(k_q)*X_W +: X_W];
        x_ext   = P_W'($signed({1'b0, x_k}));
        w_ext   = P_W'($signed(w_rdata));
        prod    = x_ext * w_ext;
        acc_sum = acc_q + ACC_W'(prod);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;

        if (en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (x_valid_i) begin
                        x_d     = x_i;
                        k_d     = '0;
                        n_d     = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    if (int'(k_q) == N_IN - 1) begin
                        // Last product of this neuron folds straight into the
                        // result slot rather than through the accumulator.
                        y_d[int'(n_q)*ACC_W +: ACC_W] =
                            ACC_W'(relu(RELU_MAX_W'(acc_sum), ACC_W));
                        acc_d = '0;
                        k_d   = '0;
                        if (int'(n_q) == N_NEUR - 1) begin
                            n_d     = '0;
                            state_d = OUT;
                        end else begin
                            n_d = n_q + NN_W'(1);
                        end
                    end else begin
                        acc_d = acc_sum;
                        k_d   = k_q + K_W'(1);
                    end
                end
                OUT: begin
                    if (y_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // rst_i masks ready so nothing is offered while reset is being applied.
    assign x_ready_o = (state_q == IDLE) && en_i && !rst_i;
    assign y_valid_o = (state_q == OUT);
    assign busy_o    = (state_q == MAC);
    assign y_o       = y_q;

endmodule

// File: tb/tb_hidden_layer_seq.sv
module tb_hidden_layer_seq;

    localparam int N_IN   = 4;
    localparam int N_NEUR = 8;
    localparam int X_W    = 4;
    localparam int W_W    = 4;
    localparam int ACC_W  = X_W + W_W + 1 + $clog2(N_IN);
    localparam int NW     = N_IN * N_NEUR;
    localparam int WA_W   = $clog2(NW);
    localparam int LAT    = NW + 1;
    localparam int BUDGET = 300;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     w_we;
    logic [WA_W-1:0]          w_addr;
    logic [W_W-1:0]           w_data;
    logic                     x_valid;
    logic                     x_ready;
    logic [N_IN*X_W-1:0]      x_vec;
    logic                     y_valid;
    logic                     y_ready;
    logic [N_NEUR*ACC_W-1:0]  y;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: signed weights and the current input vector.
    int w_m [NW];
    int x_m [N_IN];

    always #5 clk = ~clk;

    hidden_layer_seq #(
        .N_IN   (N_IN),
        .N_NEUR (N_NEUR),
        .X_W    (X_W),
        .W_W    (W_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .w_we_i    (w_we),
        .w_addr_i  (w_addr),
        .w_data_i  (w_data),
        .x_valid_i (x_valid),
        .x_ready_o (x_ready),
        .x_i       (x_vec),
        .y_valid_o (y_valid),
        .y_ready_i (y_ready),
        .y_o       (y),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sext_w(input int d);
        int v;
        v = d;
        if (v >= (1 << (W_W - 1))) v -= (1 << W_W);
        return v;
    endfunction

    function automatic longint exp_y(input int n);
        longint s;
        s = 0;
        for (int k = 0; k < N_IN; k++) s += longint'(x_m[k]) * longint'(w_m[n*N_IN+k]);
        return (s < 0) ? 0 : s;
    endfunction

    function automatic longint y_slot(input int n);
        return longint'(y[n*ACC_W +: ACC_W]);
    endfunction

    task automatic write_w(input int addr, input int data, input bit taken);
        w_we   = 1'b1;
        w_addr = WA_W'(addr);
        w_data = W_W'(data);
        tick();
        w_we   = 1'b0;
        if (taken) w_m[addr] = sext_w(data & ((1 << W_W) - 1));
    endtask

    task automatic set_x();
        for (int k = 0; k < N_IN; k++) x_vec[k*X_W +: X_W] = X_W'(x_m[k]);
    endtask

    task automatic check_slots(input string tag);
        for (int n = 0; n < N_NEUR; n++) chk($sformatf("%s/y%0d", tag, n), y_slot(n), exp_y(n));
    endtask

    // Sends one vector and checks latency, results, hold behaviour and the
    // return to IDLE. gap_at/gap_len insert an en_i=0 window mid-MAC;
    // wr_at issues a (to be dropped) write of 5 to address 0 during MAC.
    task automatic run_vector(input int gap_at, input int gap_len, input int wr_at,
                              input int rdy_delay, input string tag);
        int cnt;
        set_x();
        x_valid = 1'b1;
        chk({tag, "/x_ready_idle"}, x_ready, 1);
        tick();
        x_valid = 1'b0;
        chk({tag, "/busy_start"}, busy, 1);
        cnt = 0;
        while (!y_valid && cnt < BUDGET) begin
            if (gap_len > 0 && cnt == gap_at) en = 1'b0;
            if (gap_len > 0 && cnt == gap_at + gap_len) en = 1'b1;
            if (cnt == wr_at) begin
                w_we = 1'b1; w_addr = '0; w_data = W_W'(5);
            end else begin
                w_we = 1'b0;
            end
            tick();
            cnt++;
        end
        w_we = 1'b0;
        en   = 1'b1;
        chk({tag, "/latency"}, cnt + 1, LAT + gap_len);
        chk({tag, "/busy_out"}, busy, 0);
        check_slots(tag);
        for (int i = 0; i < rdy_delay; i++) begin
            tick();
            chk({tag, "/hold_valid"}, y_valid, 1);
            chk({tag, "/hold_xrdy"}, x_ready, 0);
            check_slots({tag, "/hold"});
        end
        if (rdy_delay > 0) begin
            en      = 1'b0;
            y_ready = 1'b1;
            tick();
            chk({tag, "/en0_valid"}, y_valid, 1);
            en = 1'b1;
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk({tag, "/idle_valid"}, y_valid, 0);
        chk({tag, "/idle_xrdy"}, x_ready, 1);
        chk({tag, "/idle_y0"}, y_slot(0), exp_y(0));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        x_valid = 1'b0; y_ready = 1'b0; x_vec = '0;
        for (int i = 0; i < NW; i++) w_m[i] = 0;
        for (int k = 0; k < N_IN; k++) x_m[k] = 0;
        tick();
        tick();
        chk("rst/x_ready", x_ready, 0);
        chk("rst/y_valid", y_valid, 0);
        chk("rst/busy", busy, 0);
        for (int n = 0; n < N_NEUR; n++) chk("rst/y", y_slot(n), 0);
        rst = 1'b0;
        #1;
        chk("rst_rel/x_ready", x_ready, 1);

        // All weights 1, x = {0,1,2,3} (k3..k0): every neuron is 6.
        for (int a = 0; a < NW; a++) write_w(a, 1, 1'b1);
        x_m[0] = 3; x_m[1] = 2; x_m[2] = 1; x_m[3] = 0;
        run_vector(-1, 0, -1, 0, "ones");
        for (int n = 0; n < N_NEUR; n++) chk("ones/six", y_slot(n), 6);

        // Neuron 0 at -8, neuron 1 at 7, x all 15; hold ready low 10 cycles.
        for (int k = 0; k < N_IN; k++) begin
            write_w(k, 8, 1'b1);
            write_w(N_IN + k, 7, 1'b1);
            x_m[k] = 15;
        end
        run_vector(-1, 0, -1, 10, "extreme");
        chk("extreme/y0", y_slot(0), 0);
        chk("extreme/y1", y_slot(1), 420);

        // Write during MAC is dropped, also on the following vector.
        for (int k = 0; k < N_IN; k++) x_m[k] = $urandom_range(15);
        run_vector(-1, 0, 5, 0, "wr_mac");
        run_vector(-1, 0, -1, 0, "wr_mac_next");
        // Write in IDLE with en_i low is dropped too.
        en = 1'b0;
        write_w(1, 3, 1'b0);
        en = 1'b1;
        write_w(0, 5, 1'b1);
        run_vector(-1, 0, -1, 1, "wr_idle");

        // en_i gap of 5 cycles mid-MAC.
        run_vector(10, 5, -1, 0, "gap");

        // Reset at MAC cycle 12.
        for (int k = 0; k < N_IN; k++) x_m[k] = 1 + $urandom_range(14);
        set_x();
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst/y_valid", y_valid, 0);
        chk("mid_rst/busy", busy, 0);
        chk("mid_rst/x_ready", x_ready, 0);
        for (int n = 0; n < N_NEUR; n++) chk("mid_rst/y", y_slot(n), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst/x_ready_rel", x_ready, 1);
        for (int i = 0; i < NW; i++) w_m[i] = 0;
        run_vector(-1, 0, -1, 0, "post_rst");

        // Randomised traffic.
        for (int it = 0; it < 20; it++) begin
            int nwr;
            nwr = (it == 0) ? NW : $urandom_range(6);
            for (int j = 0; j < nwr; j++)
                write_w((it == 0) ? j : $urandom_range(NW - 1), $urandom_range((1 << W_W) - 1), 1'b1);
            for (int k = 0; k < N_IN; k++) x_m[k] = $urandom_range((1 << X_W) - 1);
            run_vector($urandom_range(2, 20), $urandom_range(3), -1, $urandom_range(3),
                       $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
